// File: rtl/vx_div_share_arb.sv
// Round-robin arbiter that lends one iterative divider (strobe/busy handshake)
// to NUM_REQS requesters, one operation in flight, returning result and tag to the owner.
module vx_div_share_arb #(
   parameter int NUM_REQS = 4,
   parameter int DATAW    = 64,
   parameter int RESULTW  = 64,
   parameter int TAG_W    = 8,
   parameter int PERF_W   = 32
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic [NUM_REQS-1:0]            req_valid,
   output logic [NUM_REQS-1:0]            req_ready,
   input  logic [NUM_REQS-1:0][DATAW-1:0] req_data,
   input  logic [NUM_REQS-1:0][TAG_W-1:0] req_tag,
   output logic [NUM_REQS-1:0]            rsp_valid,
   input  logic [NUM_REQS-1:0]            rsp_ready,
   output logic [RESULTW-1:0]             rsp_data,
   output logic [TAG_W-1:0]               rsp_tag,
   output logic                           div_strobe,
   output logic [DATAW-1:0]               div_data,
   input  logic                           div_busy,
   input  logic [RESULTW-1:0]             div_result,
   output logic [PERF_W-1:0]              perf_busy_cycles
);
   localparam int IDX_W = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1;

   typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

   state_t              state_reg;
   logic [IDX_W-1:0]    owner_reg;
   logic [IDX_W-1:0]    rr_ptr_reg;
   logic [TAG_W-1:0]    tag_reg;
   logic [RESULTW-1:0]  result_reg;
   logic                busy_seen_reg;
   logic [PERF_W-1:0]   perf_reg;

   logic [NUM_REQS-1:0][IDX_W-1:0] cand_idx;
   logic [NUM_REQS-1:0]            cand_valid;
   logic                           grant_found;
   logic [IDX_W-1:0]               grant_idx;
   logic                           active_idle;
   logic                           fire;
   logic [IDX_W-1:0]               next_ptr;

   // Candidate gi is the requester gi positions after rr_ptr, wrapping at NUM_REQS.
   for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_cand
      logic [IDX_W:0] sum;
      assign sum = {1'b0, rr_ptr_reg} + (IDX_W+1)'(gi);
      assign cand_idx[gi] = (sum >= (IDX_W+1)'(NUM_REQS)) ?
                            IDX_W'(sum - (IDX_W+1)'(NUM_REQS)) : sum[IDX_W-1:0];
      assign cand_valid[gi] = req_valid[cand_idx[gi]];
   end

   // Walk from the far end so the nearest valid candidate to rr_ptr wins.
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      for (int i = NUM_REQS - 1; i >= 0; i--) begin
         if (cand_valid[i]) begin
            grant_found = 1'b1;
            grant_idx   = cand_idx[i];
         end
      end
   end

   // Ready is gated by reset so nothing is offered while reset is held.
   assign active_idle = reset_n && (state_reg == IDLE);
   assign fire        = active_idle && grant_found;
   assign next_ptr    = (owner_reg == IDX_W'(NUM_REQS - 1)) ? '0 : owner_reg + IDX_W'(1);

   for (genvar gi = 0; gi < NUM_REQS; gi++) begin : g_port
      assign req_ready[gi] = fire && (grant_idx == IDX_W'(gi));
      assign rsp_valid[gi] = (state_reg == RESP) && (owner_reg == IDX_W'(gi));
   end

   assign div_strobe       = fire;
   assign div_data         = req_data[grant_idx];
   assign rsp_data         = result_reg;
   assign rsp_tag          = tag_reg;
   assign perf_busy_cycles = perf_reg;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_reg     <= IDLE;
         owner_reg     <= '0;
         rr_ptr_reg    <= '0;
         tag_reg       <= '0;
         result_reg    <= '0;
         busy_seen_reg <= 1'b0;
         perf_reg      <= '0;
      end else begin
         if (state_reg != IDLE && perf_reg != '1) begin
            perf_reg <= perf_reg + PERF_W'(1);
         end
         case (state_reg)
            IDLE: begin
               if (fire) begin
                  owner_reg     <= grant_idx;
                  tag_reg       <= req_tag[grant_idx];
                  busy_seen_reg <= 1'b0;
                  state_reg     <= BUSY;
               end
            end
            BUSY: begin
               // A low busy before the divider has ever raised it is not completion.
               if (div_busy) begin
                  busy_seen_reg <= 1'b1;
               end else if (busy_seen_reg) begin
                  result_reg <= div_result;
                  state_reg  <= RESP;
               end
            end
            RESP: begin
               if (rsp_ready[owner_reg]) begin
                  rr_ptr_reg <= next_ptr;
                  state_reg  <= IDLE;
               end
            end
            default: state_reg <= IDLE;
         endcase
      end
   end
endmodule
